fm_meas_seq: RTL and testbench

FM_MEAS_SEQ -- requirements
Module: fm_meas_seq

---
 rtl/fm_meas_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fm_meas_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_meas_seq.sv
// -----------------------------------------------------------------------------
// fm_meas_seq
// Measurement sequencer for an FM demodulator output. After a start request
// it throws away a settling run of samples, then collects one acquisition
// window during which it tracks the signed peak values and counts rising
// zero crossings (with hysteresis, around the mid level of the previous
// window). From those it derives the modulating frequency, the peak deviation
// and the modulation index (x10) using a 20-cycle restoring divider.
//
// Ports
//   clk_8m       in   1   system clock, rising edge
//   rst_n        in   1   synchronous active-low reset
//   start        in   1   begins a measurement when seen in IDLE
//   continuous   in   1   re-arm after DONE instead of returning to IDLE
//   demod_valid  in   1   qualifies demod_data
//   demod_data   in  16   signed demodulated sample
//   busy         out  1   high whenever not IDLE
//   done         out  1   one-cycle pulse when the result outputs update
//   err          out  1   last window produced no crossings
//   mod_freq     out 13   rising-crossing count of last window (saturating)
//   delta_f      out 16   peak deviation estimate (saturating)
//   mf           out  8   floor(delta_f*10/mod_freq), saturating at 255
// -----------------------------------------------------------------------------
module fm_meas_seq #(
   parameter int SETTLE_LEN = 512,
   parameter int WIN_LEN    = 8000000,
   parameter int HYST       = 64,
   parameter int K_DF       = 256
) (
   input  logic               clk_8m,
   input  logic               rst_n,
   input  logic               start,
   input  logic               continuous,
   input  logic               demod_valid,
   input  logic signed [15:0] demod_data,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [12:0]        mod_freq,
   output logic [15:0]        delta_f,
   output logic [7:0]         mf
);

   localparam int SW = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;
   localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_LEN - 1);
   localparam logic [WW-1:0] WIN_LAST    = WW'(WIN_LEN - 1);
   localparam logic signed [16:0] HYST_POS = 17'(HYST);
   localparam logic signed [16:0] HYST_NEG = -HYST_POS;
   localparam logic [47:0] K_DF_W = 48'(K_DF);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      ACQ    = 3'd2,
      CALC   = 3'd3,
      DIV    = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t state_reg, state_next;

   // window bookkeeping
   logic [SW-1:0]      settle_cnt_reg;
   logic [WW-1:0]      win_cnt_reg;
   logic signed [15:0] max_reg;
   logic signed [15:0] min_reg;
   logic               have_sample_reg;
   logic               armed_reg;
   logic [12:0]        cross_cnt_reg;
   logic signed [15:0] mid_reg;

   // results computed in CALC, held privately until DONE
   logic [15:0] res_delta_reg;
   logic [12:0] res_freq_reg;

   // restoring divider
   logic [19:0] div_num_reg;
   logic [19:0] div_q_reg;
   logic [12:0] div_rem_reg;
   logic [4:0]  div_cnt_reg;

   // visible results
   logic        err_reg;
   logic [12:0] mod_freq_reg;
   logic [15:0] delta_f_reg;
   logic [7:0]  mf_reg;

   logic settle_last, win_last, div_last;
   assign settle_last = (settle_cnt_reg == SETTLE_LAST);
   assign win_last    = (win_cnt_reg == WIN_LAST);
   assign div_last    = (div_cnt_reg == 5'd19);

   // ---------------------------------------------------------------- datapath
   // Sample relative to the previous window's mid level, one bit wider so the
   // subtraction cannot wrap.
   logic signed [16:0] x_val;
   assign x_val = {demod_data[15], demod_data} - {mid_reg[15], mid_reg};

   logic [16:0]        span;
   logic [16:0]        amp;
   logic [47:0]        prod;
   logic [47:0]        scaled;
   logic [15:0]        delta_calc;
   logic signed [16:0] mid_sum;
   logic [19:0]        num_init;

   assign span       = {max_reg[15], max_reg} - {min_reg[15], min_reg};
   assign amp        = span >> 1;
   assign prod       = 48'(amp) * K_DF_W;
   assign scaled     = prod >> 8;
   assign delta_calc = (scaled > 48'h00_0000_FFFF) ? 16'hFFFF : scaled[15:0];
   assign mid_sum    = {max_reg[15], max_reg} + {min_reg[15], min_reg};
   assign num_init   = 20'(delta_calc) * 20'd10;

   // One restoring-division step: bring in the next numerator bit, subtract
   // the divisor if it fits.
   logic [13:0] rem_shift;
   logic [13:0] rem_sub;
   logic        rem_ge;
   logic [19:0] q_step;
   logic [7:0]  mf_calc;

   assign rem_shift = {div_rem_reg, div_num_reg[19]};
   assign rem_ge    = (rem_shift >= {1'b0, res_freq_reg});
   assign rem_sub   = rem_shift - {1'b0, res_freq_reg};
   assign q_step    = (div_q_reg << 1) | 20'(rem_ge);
   // Final quotient is taken from q_step so the last step's bit is included
   // in the same cycle the outputs are loaded.
   assign mf_calc   = (res_freq_reg == 13'd0) ? 8'hFF :
                      ((|q_step[19:8]) ? 8'hFF : q_step[7:0]);

   // --------------------------------------------------------------------- FSM
   always_ff @(posedge clk_8m) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (start) state_next = SETTLE;
         end
         SETTLE: begin
            if (demod_valid && settle_last) state_next = ACQ;
         end
         ACQ: begin
            if (demod_valid && win_last) state_next = CALC;
         end
         CALC: begin
            state_next = DIV;
         end
         DIV: begin
            if (div_last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = continuous ? SETTLE : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------- state datapath
   always_ff @(posedge clk_8m) begin
      if (!rst_n) begin
         settle_cnt_reg  <= '0;
         win_cnt_reg     <= '0;
         max_reg         <= '0;
         min_reg         <= '0;
         have_sample_reg <= 1'b0;
         armed_reg       <= 1'b0;
         cross_cnt_reg   <= '0;
         mid_reg         <= '0;
         res_delta_reg   <= '0;
         res_freq_reg    <= '0;
         div_num_reg     <= '0;
         div_q_reg       <= '0;
         div_rem_reg     <= '0;
         div_cnt_reg     <= '0;
         err_reg         <= 1'b0;
         mod_freq_reg    <= '0;
         delta_f_reg     <= '0;
         mf_reg          <= '0;
      end else begin
         // settle counter only runs in SETTLE, so each entry starts from zero
         if (state_reg == SETTLE) begin
            if (demod_valid) settle_cnt_reg <= settle_cnt_reg + SW'(1);
         end else begin
            settle_cnt_reg <= '0;
         end

         // Window statistics are cleared throughout SETTLE so they start
         // fresh on ACQ entry, and are held from ACQ exit until the next
         // SETTLE so CALC sees the finished window.
         if (state_reg == SETTLE) begin
            win_cnt_reg     <= '0;
            have_sample_reg <= 1'b0;
            armed_reg       <= 1'b0;
            cross_cnt_reg   <= '0;
         end else if (state_reg == ACQ && demod_valid) begin
            win_cnt_reg     <= win_cnt_reg + WW'(1);
            have_sample_reg <= 1'b1;
            if (!have_sample_reg) begin
               max_reg <= demod_data;
               min_reg <= demod_data;
            end else begin
               if (demod_data > max_reg) max_reg <= demod_data;
               if (demod_data < min_reg) min_reg <= demod_data;
            end
            // hysteresis: arm below -HYST, count and disarm above +HYST
            if (!armed_reg) begin
               if (x_val < HYST_NEG) armed_reg <= 1'b1;
            end else if (x_val > HYST_POS) begin
               armed_reg <= 1'b0;
               if (cross_cnt_reg != 13'h1FFF) cross_cnt_reg <= cross_cnt_reg + 13'd1;
            end
         end

         if (state_reg == CALC) begin
            res_delta_reg <= delta_calc;
            res_freq_reg  <= cross_cnt_reg;
            mid_reg       <= 16'(mid_sum >>> 1);
            div_num_reg   <= num_init;
            div_q_reg     <= '0;
            div_rem_reg   <= '0;
            div_cnt_reg   <= '0;
         end else if (state_reg == DIV) begin
            div_cnt_reg <= div_cnt_reg + 5'd1;
            div_num_reg <= div_num_reg << 1;
            // with no crossings the divider just idles for its 20 cycles
            if (res_freq_reg != 13'd0) begin
               div_rem_reg <= 13'(rem_ge ? rem_sub : rem_shift);
               div_q_reg   <= q_step;
            end
            if (div_last) begin
               mod_freq_reg <= res_freq_reg;
               delta_f_reg  <= res_delta_reg;
               mf_reg       <= mf_calc;
               err_reg      <= (res_freq_reg == 13'd0);
            end
         end
      end
   end

   assign err      = err_reg;
   assign mod_freq = mod_freq_reg;
   assign delta_f  = delta_f_reg;
   assign mf       = mf_reg;

endmodule

// File: tb/tb_fm_meas_seq.sv
// -----------------------------------------------------------------------------
// tb_fm_meas_seq
// Directed sequence of measurements with randomised waveforms, checked against
// a window-level reference model (peak search, hysteresis crossing count and
// result arithmetic) kept in the bench. The acquisition window is scaled down
// to 800 samples, with an 80-sample sine period standing in for "1 kHz", so
// each window holds ten modulation periods.
// -----------------------------------------------------------------------------
module tb_fm_meas_seq;

   localparam int SETTLE = 16;
   localparam int WIN    = 800;
   localparam int HYSTP  = 64;
   localparam int KDF    = 256;
   localparam int PER    = 80;

   logic               clk_8m = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               continuous = 1'b0;
   logic               demod_valid = 1'b0;
   logic signed [15:0] demod_data = '0;
   logic               busy;
   logic               done;
   logic               err;
   logic [12:0]        mod_freq;
   logic [15:0]        delta_f;
   logic [7:0]         mf;

   always #5 clk_8m = ~clk_8m;

   fm_meas_seq #(
      .SETTLE_LEN(SETTLE),
      .WIN_LEN   (WIN),
      .HYST      (HYSTP),
      .K_DF      (KDF)
   ) dut (
      .clk_8m     (clk_8m),
      .rst_n      (rst_n),
      .start      (start),
      .continuous (continuous),
      .demod_valid(demod_valid),
      .demod_data (demod_data),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .mod_freq   (mod_freq),
      .delta_f    (delta_f),
      .mf         (mf)
   );

   int n_vec = 0;
   int n_err = 0;
   int mid_m = 0;
   int exp_freq = 0;
   int exp_delta = 0;
   int exp_mf = 0;
   int exp_err = 0;
   int win_q[$];
   bit seen_done;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic gen_sine(input int amp, input int dc, input int period, input int noise);
      real r;
      int  y;
      win_q.delete();
      for (int i = 0; i < WIN; i++) begin
         r = -amp * $cos(2.0 * 3.14159265358979 * i / period);
         y = dc + int'(r);
         if (noise > 0 && (y - dc) > -200 && (y - dc) < 200)
            y = y + int'($urandom_range(2 * noise)) - noise;
         win_q.push_back(sat16(y));
      end
   endtask

   task automatic gen_const(input int v);
      win_q.delete();
      for (int i = 0; i < WIN; i++) win_q.push_back(v);
   endtask

   // Window-level reference: peaks, crossings against previous mid, results.
   task automatic model(output int f, output int d, output int m, output int e);
      int  mx, mn, cnt, x;
      bit  armed;
      mx = win_q[0];
      mn = win_q[0];
      cnt = 0;
      armed = 0;
      foreach (win_q[i]) begin
         if (win_q[i] > mx) mx = win_q[i];
         if (win_q[i] < mn) mn = win_q[i];
         x = win_q[i] - mid_m;
         if (!armed && x < -HYSTP) armed = 1;
         else if (armed && x > HYSTP) begin
            armed = 0;
            cnt++;
         end
      end
      mid_m = (mx + mn) >>> 1;
      d = (((mx - mn) / 2) * KDF) / 256;
      if (d > 65535) d = 65535;
      f = (cnt > 8191) ? 8191 : cnt;
      if (f == 0) begin
         m = 255;
         e = 1;
      end else begin
         m = (d * 10) / f;
         if (m > 255) m = 255;
         e = 0;
      end
   endtask

   task automatic step(input bit v, input int data);
      @(negedge clk_8m);
      if (done) seen_done = 1;
      demod_valid = v;
      demod_data  = 16'(data);
   endtask

   task automatic feed(input int v, input int gap);
      int g;
      g = (gap < 0) ? int'($urandom_range(2)) : gap;
      repeat (g) step(0, int'($urandom));
      step(1, v);
   endtask

   task automatic do_start();
      @(negedge clk_8m);
      demod_valid = 0;
      start = 1;
      @(negedge clk_8m);
      start = 0;
   endtask

   task automatic run_window(input int gap, input bit poke_start, input bit drop_cont,
                             input bit abort, input string name);
      int f, d, m, e, lat;
      chk({name, "_hold_freq"}, mod_freq, exp_freq);
      chk({name, "_hold_mf"}, mf, exp_mf);
      seen_done = 0;
      for (int s = 0; s < SETTLE; s++) feed(int'($urandom_range(65535)) - 32768, gap);
      for (int i = 0; i < WIN; i++) begin
         if (drop_cont && i == WIN / 2) continuous = 0;
         if (poke_start && i == WIN / 3) start = 1;
         feed(win_q[i], gap);
         start = 0;
      end
      chk({name, "_no_done_in_window"}, seen_done, 0);
      chk({name, "_busy_in_window"}, busy, 1);
      model(f, d, m, e);
      if (abort) begin
         repeat (10) step(0, 0);
         rst_n = 0;
         step(0, 0);
         rst_n = 1;
         seen_done = 0;
         repeat (30) step(0, 0);
         chk({name, "_no_done_after_abort"}, seen_done, 0);
         chk({name, "_busy_after_abort"}, busy, 0);
         chk({name, "_freq_after_abort"}, mod_freq, 0);
         chk({name, "_delta_after_abort"}, delta_f, 0);
         chk({name, "_mf_after_abort"}, mf, 0);
         chk({name, "_err_after_abort"}, err, 0);
         exp_freq = 0; exp_delta = 0; exp_mf = 0; exp_err = 0;
         mid_m = 0;
      end else begin
         lat = 0;
         for (int c = 1; c <= 60; c++) begin
            step(0, 0);
            if (done) begin
               lat = c;
               break;
            end
         end
         chk({name, "_latency"}, lat, 22);
         chk({name, "_mod_freq"}, mod_freq, f);
         chk({name, "_delta_f"}, delta_f, d);
         chk({name, "_mf"}, mf, m);
         chk({name, "_err"}, err, e);
         exp_freq = f; exp_delta = d; exp_mf = m; exp_err = e;
      end
   endtask

   task automatic gen_random();
      gen_sine(int'($urandom_range(20000, 50)), int'($urandom_range(6000)) - 3000,
               int'($urandom_range(400, 30)), int'($urandom_range(40)));
   endtask

   initial begin
      bit busy_seen;

      // reset state
      rst_n = 0;
      repeat (3) @(negedge clk_8m);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_mod_freq", mod_freq, 0);
      chk("rst_delta_f", delta_f, 0);
      chk("rst_mf", mf, 0);
      rst_n = 1;

      // no activity without start, even with valid samples
      busy_seen = 0;
      for (int i = 0; i < 20; i++) begin
         step(1, int'($urandom_range(4000)) - 2000);
         if (busy) busy_seen = 1;
      end
      chk("idle_no_start", busy_seen, 0);
      step(0, 0);

      // two continuous windows, amplitude 1000; continuous dropped in the second
      continuous = 1;
      gen_sine(1000, 0, PER, 0);
      do_start();
      run_window(0, 0, 0, 0, "A1");
      gen_sine(1000, 0, PER, 0);
      run_window(0, 0, 1, 0, "A2");
      chk("A2_freq_10", mod_freq, 10);
      chk("A2_delta_1000", delta_f, 1000);
      chk("A2_mf_sat", mf, 255);
      chk("A2_err0", err, 0);
      step(0, 0);
      chk("A2_idle_after_drop", busy, 0);

      // single shot, amplitude 100, start poked during ACQ
      gen_sine(100, 0, PER, 0);
      do_start();
      run_window(0, 1, 0, 0, "B");
      chk("B_freq_10", mod_freq, 10);
      chk("B_delta_100", delta_f, 100);
      chk("B_mf_100", mf, 100);
      step(0, 0);
      chk("B_idle", busy, 0);

      // constant input: no crossings
      gen_const(300);
      do_start();
      run_window(0, 0, 0, 0, "C");
      chk("C_freq_0", mod_freq, 0);
      chk("C_err_1", err, 1);
      chk("C_mf_255", mf, 255);
      chk("C_delta_0", delta_f, 0);

      // random waveform against the mid level left by the constant window
      gen_random();
      do_start();
      run_window(-1, 0, 0, 0, "D");

      // reset asserted mid-DIV
      gen_sine(500, 0, PER, 0);
      do_start();
      run_window(0, 0, 0, 1, "E");

      // valid toggling every cycle
      gen_sine(100, 0, PER, 0);
      do_start();
      run_window(1, 0, 0, 0, "F");
      chk("F_freq_10", mod_freq, 10);
      chk("F_delta_100", delta_f, 100);
      chk("F_mf_100", mf, 100);

      // noise around the crossings stays inside the hysteresis band
      gen_sine(1000, 0, PER, 50);
      do_start();
      run_window(0, 0, 0, 0, "G");
      chk("G_freq_10", mod_freq, 10);
      chk("G_delta_1000", delta_f, 1000);

      // random continuous run of three windows
      continuous = 1;
      for (int w = 0; w < 3; w++) begin
         gen_random();
         if (w == 0) do_start();
         run_window(-1, 0, (w == 2), 0, $sformatf("H%0d", w));
      end
      step(0, 0);
      chk("H_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
